// File: rtl/cm0_dap_cdc_recv_data.sv
// rtl/cm0_dap_cdc_recv_data.sv - 4-phase CDC receive register with local valid/ready hand-off
module cm0_dap_cdc_recv_data #(
    parameter int PRESENT     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        REGCLK,
    input  logic        RARREGRESETn,
    input  logic        REQ,
    input  logic [31:0] REGDI,
    input  logic        SE,
    input  logic        DREADY,
    output logic        DVALID,
    output logic [31:0] DOUT,
    output logic        ACK
);

    generate
        if (PRESENT != 0) begin : g_present

            typedef enum logic [1:0] {
                ST_IDLE  = 2'd0,
                ST_VALID = 2'd1,
                ST_ACKH  = 2'd2
            } state_t;

            state_t                 state_q;
            state_t                 state_d;
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   req_s;
            logic                   capture;
            logic [31:0]            dout_q;
            logic                   dvalid_q;
            logic                   ack_q;
            logic                   unused_se;

            // Scan enable carries no functional meaning inside this block.
            assign unused_se = SE;

            // REQ synchroniser: the only place the asynchronous request is sampled.
            always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
                if (!RARREGRESETn) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], REQ};
                end
            end

            assign req_s = sync_q[SYNC_STAGES-1];

            // Next-state: capture on request, hand off on ready, release on request low.
            always_comb begin
                state_d = state_q;
                capture = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (req_s) begin
                            state_d = ST_VALID;
                            capture = 1'b1;
                        end
                    end
                    ST_VALID: begin
                        if (DREADY) begin
                            state_d = ST_ACKH;
                        end
                    end
                    ST_ACKH: begin
                        if (!req_s) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // State register; DVALID and ACK are decoded from the next state so both leave a flop.
            always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
                if (!RARREGRESETn) begin
                    state_q  <= ST_IDLE;
                    dvalid_q <= 1'b0;
                    ack_q    <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    dvalid_q <= (state_d == ST_VALID);
                    ack_q    <= (state_d == ST_ACKH);
                end
            end

            // Data register: REGDI is only looked at on the IDLE-to-VALID edge.
            always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
                if (!RARREGRESETn) begin
                    dout_q <= 32'h0;
                end else if (capture) begin
                    dout_q <= REGDI;
                end
            end

            assign DVALID = dvalid_q;
            assign ACK    = ack_q;
            assign DOUT   = dout_q;

        end else begin : g_absent

            logic [36:0] unused_absent;

            assign unused_absent = {REGCLK, RARREGRESETn, REQ, SE, DREADY, REGDI};
            assign DVALID        = 1'b0;
            assign ACK           = 1'b0;
            assign DOUT          = 32'h0;

        end
    endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_recv_data.sv
// tb/tb_cm0_dap_cdc_recv_data.sv - self-checking bench for cm0_dap_cdc_recv_data
module tb_cm0_dap_cdc_recv_data;

    logic        REGCLK       = 1'b0;
    logic        RARREGRESETn = 1'b0;
    logic        REQ          = 1'b0;
    logic [31:0] REGDI        = 32'h0;
    logic        SE           = 1'b0;
    logic        DREADY       = 1'b0;
    logic        DVALID;
    logic [31:0] DOUT;
    logic        ACK;
    logic        off_dvalid;
    logic [31:0] off_dout;
    logic        off_ack;

    int checks = 0;
    int errors = 0;

    logic [31:0] hs_q[$];
    logic [31:0] exp_seq[4] = '{32'h1, 32'h2, 32'h4, 32'h8};

    cm0_dap_cdc_recv_data #(.PRESENT(1), .SYNC_STAGES(2)) u_dut (
        .REGCLK(REGCLK), .RARREGRESETn(RARREGRESETn), .REQ(REQ), .REGDI(REGDI),
        .SE(SE), .DREADY(DREADY), .DVALID(DVALID), .DOUT(DOUT), .ACK(ACK)
    );

    cm0_dap_cdc_recv_data #(.PRESENT(0), .SYNC_STAGES(2)) u_off (
        .REGCLK(REGCLK), .RARREGRESETn(RARREGRESETn), .REQ(REQ), .REGDI(REGDI),
        .SE(SE), .DREADY(DREADY), .DVALID(off_dvalid), .DOUT(off_dout), .ACK(off_ack)
    );

    always #5 REGCLK = ~REGCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: request seen two edges late, one word held until
    // consumed, then acknowledged until the request is seen low again.
    logic [1:0]  m_req_hist;
    logic        m_holding;
    logic        m_acking;
    logic [31:0] m_word;

    always @(posedge REGCLK or negedge RARREGRESETn) begin
        if (!RARREGRESETn) begin
            m_req_hist <= 2'b00;
            m_holding  <= 1'b0;
            m_acking   <= 1'b0;
            m_word     <= 32'h0;
        end else begin
            m_req_hist <= {m_req_hist[0], REQ};
            if (m_acking) begin
                if (!m_req_hist[1]) m_acking <= 1'b0;
            end else if (m_holding) begin
                if (DREADY) begin
                    m_holding <= 1'b0;
                    m_acking  <= 1'b1;
                end
            end else if (m_req_hist[1]) begin
                m_holding <= 1'b1;
                m_word    <= REGDI;
            end
        end
    end

    // Every-cycle comparison against the model and the removed instance.
    always @(posedge REGCLK) begin
        #1;
        check("model_dvalid", DVALID, m_holding);
        check("model_ack", ACK, m_acking);
        check("model_dout", DOUT, m_word);
        check("absent_outputs", {off_dvalid, off_ack, off_dout}, 34'h0);
    end

    // Record each consumed word on the falling edge where inputs are stable.
    always @(negedge REGCLK) begin
        if (DVALID === 1'b1 && DREADY === 1'b1) hs_q.push_back(DOUT);
    end

    task automatic tick();
        @(posedge REGCLK);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n = 0;
        while (ACK !== v && n < 20) begin
            tick();
            n++;
        end
        check(name, ACK, v);
    endtask

    task automatic xfer(input logic [31:0] d);
        REGDI = d;
        REQ   = 1'b1;
        wait_ack(1'b1, "xfer_ack_rise");
        REQ = 1'b0;
        wait_ack(1'b0, "xfer_ack_fall");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset state and clean release.
        repeat (2) tick();
        check("rst_dvalid", DVALID, 1'b0);
        check("rst_ack", ACK, 1'b0);
        check("rst_dout", DOUT, 32'h0);
        RARREGRESETn = 1'b1;
        repeat (2) tick();
        check("release_ack", ACK, 1'b0);

        // Basic transfer with exact latency.
        REGDI  = 32'hDEADBEEF;
        DREADY = 1'b1;
        REQ    = 1'b1;
        tick(); check("basic_n_dvalid", DVALID, 1'b0);
        tick(); check("basic_n1_dvalid", DVALID, 1'b0);
        tick(); check("basic_n2_dvalid", DVALID, 1'b1);
        check("basic_n2_dout", DOUT, 32'hDEADBEEF);
        check("basic_n2_ack", ACK, 1'b0);
        tick(); check("basic_n3_ack", ACK, 1'b1);
        check("basic_n3_dvalid", DVALID, 1'b0);
        REQ = 1'b0;
        tick(); check("basic_m_ack", ACK, 1'b1);
        tick(); check("basic_m1_ack", ACK, 1'b1);
        tick(); check("basic_m2_ack", ACK, 1'b0);
        check("basic_idle_dout", DOUT, 32'hDEADBEEF);

        // Backpressure plus data stability.
        REGDI  = 32'hA5A50001;
        DREADY = 1'b0;
        REQ    = 1'b1;
        repeat (3) tick();
        check("bp_dvalid", DVALID, 1'b1);
        check("bp_dout", DOUT, 32'hA5A50001);
        REGDI = 32'hFFFF0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_dvalid", DVALID, 1'b1);
            check("bp_hold_ack", ACK, 1'b0);
            check("bp_hold_dout", DOUT, 32'hA5A50001);
        end
        DREADY = 1'b1;
        tick(); check("bp_ack", ACK, 1'b1);
        check("bp_ack_dvalid", DVALID, 1'b0);
        REQ = 1'b0;
        repeat (2) tick();
        check("bp_ack_held", ACK, 1'b1);
        tick(); check("bp_ack_fall", ACK, 1'b0);
        check("bp_dout_kept", DOUT, 32'hA5A50001);

        // Back-to-back transfers.
        hs_q.delete();
        for (int i = 0; i < 4; i++) xfer(exp_seq[i]);
        check("b2b_count", hs_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_word", (i < hs_q.size()) ? hs_q[i] : 32'hX, exp_seq[i]);
        end

        // Reset while acknowledging, request still high afterwards.
        REGDI  = 32'h12345678;
        DREADY = 1'b1;
        REQ    = 1'b1;
        repeat (4) tick();
        check("racq_ack", ACK, 1'b1);
        #2 RARREGRESETn = 1'b0;
        #1;
        check("racq_rst_ack", ACK, 1'b0);
        check("racq_rst_dvalid", DVALID, 1'b0);
        check("racq_rst_dout", DOUT, 32'h0);
        repeat (2) tick();
        RARREGRESETn = 1'b1;
        tick(); check("racq_e1_dvalid", DVALID, 1'b0);
        check("racq_e1_ack", ACK, 1'b0);
        tick(); check("racq_e2_dvalid", DVALID, 1'b0);
        tick(); check("racq_e3_dvalid", DVALID, 1'b1);
        check("racq_e3_dout", DOUT, 32'h12345678);
        tick(); check("racq_ack2", ACK, 1'b1);
        REQ = 1'b0;
        repeat (3) tick();
        check("racq_ack2_fall", ACK, 1'b0);

        // Request withdrawn while data is still pending.
        REGDI  = 32'hCAFEF00D;
        DREADY = 1'b0;
        REQ    = 1'b1;
        repeat (3) tick();
        check("pv_dvalid", DVALID, 1'b1);
        REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pv_hold_dvalid", DVALID, 1'b1);
            check("pv_hold_ack", ACK, 1'b0);
        end
        DREADY = 1'b1;
        tick(); check("pv_ack", ACK, 1'b1);
        check("pv_ack_dvalid", DVALID, 1'b0);
        tick(); check("pv_ack_one_cycle", ACK, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pv_quiet_ack", ACK, 1'b0);
            check("pv_quiet_dvalid", DVALID, 1'b0);
            check("pv_quiet_dout", DOUT, 32'hCAFEF00D);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
